// File: rtl/bcd_ascii_scheduler.sv
// Round-robin shared binary-to-BCD converter: grants one 22-bit requester,
// runs one double-dabble step per clock, then streams 7 ASCII digits MSD first.
module bcd_ascii_scheduler #(
  parameter int NREQ  = 4,
  parameter bit BLANK = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*22-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               char_valid,
  input  logic               char_ready,
  output logic [7:0]         char_data,
  output logic [2:0]         char_src,
  output logic               char_last,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  rr_q, rr_d;
  logic [2:0]  src_q, src_d;
  logic [2:0]  idx_q, idx_d;
  logic [4:0]  iter_q, iter_d;
  logic [21:0] bin_q, bin_d;
  logic [27:0] bcd_q, bcd_d;

  // Requests padded to 8 slots so every select uses a fixed 3-bit index.
  logic [7:0]       vld8;
  logic [8*22-1:0]  data8;
  logic             gnt_any;
  logic [2:0]       gsel;
  logic [2:0]       cand;
  logic [7:0]       gbase;

  assign vld8  = 8'(req_valid);
  assign data8 = (8*22)'(req_data);
  assign gbase = 8'(gsel) * 8'd22;

  always_comb begin
    gnt_any = 1'b0;
    gsel    = 3'd0;
    cand    = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = 3'((int'(rr_q) + k) % NREQ);
      if (!gnt_any && vld8[cand]) begin
        gnt_any = 1'b1;
        gsel    = cand;
      end
    end
  end

  assign req_ready = (state_q == IDLE && !reset && gnt_any) ? NREQ'(8'b1 << gsel) : '0;

  // Add-3 correction on every digit before the shift.
  logic [27:0] adj;
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < 7; d++)
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        bin_d   = data8[gbase +: 22];
        bcd_d   = '0;
        iter_d  = '0;
        src_d   = gsel;
        rr_d    = (int'(gsel) == NREQ - 1) ? 3'd0 : gsel + 3'd1;
        state_d = CONV;
      end
      CONV: begin
        bcd_d  = {adj[26:0], bin_q[21]};
        bin_d  = {bin_q[20:0], 1'b0};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd21) begin
          state_d = EMIT;
          idx_d   = 3'd6;
        end
      end
      EMIT: if (char_ready) begin
        if (idx_q == 3'd0) state_d = IDLE;
        else               idx_d   = idx_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      src_q   <= '0;
      idx_q   <= '0;
      iter_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  // A zero digit is blanked only while every more-significant digit is zero too.
  logic [3:0]  digit;
  logic [27:0] higher;
  logic        blank;
  assign digit  = bcd_q[{idx_q, 2'b00} +: 4];
  assign higher = bcd_q >> ({idx_q, 2'b00} + 5'd4);
  assign blank  = BLANK && (digit == 4'd0) && (higher == '0) && (idx_q != 3'd0);

  assign char_valid = (state_q == EMIT);
  assign char_data  = (state_q != EMIT) ? 8'h00 : blank ? 8'h20 : {4'h3, digit};
  assign char_src   = (state_q == EMIT) ? src_q : 3'd0;
  assign char_last  = (state_q == EMIT) && (idx_q == 3'd0);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_ascii_scheduler.sv
// Bench for bcd_ascii_scheduler: vector table, hand sequences and random
// traffic scored against a decimal-formatting and round-robin model.
module tb_bcd_ascii_scheduler;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*22-1:0]  req_data = '0;
  logic [N-1:0]     req_ready;
  logic             char_valid, char_last, busy;
  logic             char_ready = 1'b1;
  logic [7:0]       char_data;
  logic [2:0]       char_src;

  logic             b_req_valid = 1'b0;
  logic [21:0]      b_req_data = '0;
  logic [0:0]       b_req_ready;
  logic             b_char_valid, b_char_last, b_busy;
  logic             b_char_ready = 1'b1;
  logic [7:0]       b_char_data;
  logic [2:0]       b_char_src;

  bcd_ascii_scheduler #(.NREQ(N), .BLANK(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .char_src(char_src), .char_last(char_last), .busy(busy));

  bcd_ascii_scheduler #(.NREQ(1), .BLANK(1'b0)) u_dut_z (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .char_valid(b_char_valid), .char_ready(b_char_ready),
    .char_data(b_char_data), .char_src(b_char_src), .char_last(b_char_last), .busy(b_busy));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Reference formatting: right-justified decimal, leading zeros as spaces.
  function automatic logic [55:0] fmt(input int v, input bit blank);
    logic [55:0] r;
    int p;
    p = 1000000;
    r = '0;
    for (int k = 0; k < 7; k++) begin
      if (blank && v < p && k < 6) r[8*(6-k) +: 8] = 8'h20;
      else                         r[8*(6-k) +: 8] = 8'(8'h30 + (v / p) % 10);
      p = p / 10;
    end
    return r;
  endfunction

  typedef struct { int value; logic [55:0] exp; } item_t;
  typedef struct { int src; logic [55:0] exp; int gedge; } frame_t;
  typedef struct { int src; int value; logic [55:0] exp; } vec_t;

  item_t  pend[N][$];
  frame_t expq[$];
  int     gedge_q[$];
  int     gsrc_q[$];
  int     cyc = 0;
  int     mptr = 0;
  int     nacc = 0;
  int     ccnt = 0;
  logic [N-1:0] gnt_mask = '0;
  logic   prev_valid = 1'b0;
  logic   stalled = 1'b0;
  logic [7:0] held_data;
  logic [2:0] held_src;
  logic   held_last;
  int     m_e, m_gi;
  int     rdy_mode = 0;
  int     rdy_force = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: sampled mid-cycle, so each observation describes the next edge.
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      ccnt = 0;
      mptr = 0;
      prev_valid = 1'b0;
      stalled = 1'b0;
    end else begin
      if ((req_valid & req_ready) != '0) begin
        m_e = -1;
        for (int k = 0; k < N; k++)
          if (m_e < 0 && req_valid[(mptr + k) % N]) m_e = (mptr + k) % N;
        m_gi = 0;
        for (int k = 0; k < N; k++) if (req_ready[k]) m_gi = k;
        check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
        check("grant_index", 64'(m_gi), 64'(m_e));
        expq.push_back('{m_e, pend[m_e][0].exp, cyc + 1});
        gedge_q.push_back(cyc + 1);
        gsrc_q.push_back(m_gi);
        gnt_mask = req_ready;
        mptr = (m_e + 1) % N;
      end
      if (char_valid && !prev_valid && expq.size() > 0)
        check("latency", 64'(cyc - expq[0].gedge), 64'd22);
      prev_valid = char_valid;
      if (stalled && char_valid) begin
        check("stall_data", 64'(char_data), 64'(held_data));
        check("stall_src", 64'(char_src), 64'(held_src));
        check("stall_last", 64'(char_last), 64'(held_last));
      end
      stalled   = char_valid && !char_ready;
      held_data = char_data;
      held_src  = char_src;
      held_last = char_last;
      if (char_valid && char_ready) begin
        if (expq.size() == 0) fail("unexpected_char");
        else begin
          check("char_data", 64'(char_data), 64'(expq[0].exp[8*(6-ccnt) +: 8]));
          check("char_src", 64'(char_src), 64'(expq[0].src));
          check("char_last", 64'(char_last), 64'(ccnt == 6));
          ccnt++;
          if (ccnt == 7) begin
            ccnt = 0;
            void'(expq.pop_front());
          end
        end
        nacc++;
      end
    end
  end

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pend[i].size() > 0);
      req_data[i*22 +: 22] = (pend[i].size() > 0) ? 22'(pend[i][0].value) : 22'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (gnt_mask[i]) void'(pend[i].pop_front());
    gnt_mask = '0;
    if (rdy_force > 0) begin
      char_ready = 1'b0;
      rdy_force--;
    end else char_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    drive_reqs();
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((expq.size() > 0 || any_pend() || busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail("drain_timeout");
  endtask

  task automatic push(input int src, input int v);
    pend[src].push_back('{v, fmt(v, 1'b1)});
  endtask

  task automatic b_frame(input int v);
    int n, k;
    logic [55:0] e;
    e = fmt(v, 1'b0);
    b_req_valid = 1'b1;
    b_req_data  = 22'(v);
    n = 0;
    @(negedge clk);
    while (!b_req_ready[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) fail("zpad_grant_timeout");
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
    n = 0;
    k = 0;
    while (k < 7 && n < 60) begin
      @(negedge clk);
      n++;
      if (b_char_valid) begin
        check("zpad_char", 64'(b_char_data), 64'(e[8*(6-k) +: 8]));
        check("zpad_last", 64'(b_char_last), 64'(k == 6));
        check("zpad_src", 64'(b_char_src), 64'd0);
        k++;
      end
    end
    if (k < 7) fail("zpad_frame_timeout");
    tick();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  vec_t vt[7];
  int   p10[7] = '{1, 10, 100, 1000, 10000, 100000, 1000000};

  initial begin
    vt[0] = '{0, 0,       "      0"};
    vt[1] = '{1, 4194303, "4194303"};
    vt[2] = '{2, 1000000, "1000000"};
    vt[3] = '{0, 123,     "    123"};
    vt[4] = '{1, 10,      "     10"};
    vt[5] = '{2, 99999,   "  99999"};
    vt[6] = '{3, 9,       "      9"};

    req_valid = 4'b0010;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_char_valid", 64'(char_valid), 64'd0);
    check("rst_char_data", 64'(char_data), 64'd0);
    check("rst_char_src", 64'(char_src), 64'd0);
    check("rst_char_last", 64'(char_last), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    reset = 1'b0;
    tick();

    foreach (vt[i]) begin
      pend[vt[i].src].push_back('{vt[i].value, vt[i].exp});
      drive_reqs();
      wait_drain(200);
    end

    b_frame(0);
    b_frame(4194303);

    // Fairness with all four requesters held valid.
    reset_pulse();
    gedge_q.delete();
    gsrc_q.delete();
    push(0, 1); push(1, 2); push(2, 3); push(3, 4); push(0, 5);
    drive_reqs();
    wait_drain(400);
    check("fair_frames", 64'(gedge_q.size()), 64'd5);
    for (int k = 0; k < 5 && k < gsrc_q.size(); k++)
      check("fair_order", 64'(gsrc_q[k]), 64'(k % 4));
    for (int k = 1; k < gedge_q.size(); k++)
      check("fair_spacing", 64'(gedge_q[k] - gedge_q[k-1]), 64'd30);

    // Backpressure: stall at the third character, then random ready.
    begin
      int base, n;
      base = nacc;
      push(0, 123456);
      drive_reqs();
      n = 0;
      while (nacc < base + 2 && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) fail("bp_timeout");
      char_ready = 1'b0;
      rdy_force = 4;
      rdy_mode = 1;
      wait_drain(500);
      check("bp_chars", 64'(nacc - base), 64'd7);
      rdy_mode = 0;
    end

    // A requester that withdraws before IDLE is never served.
    push(0, 42);
    drive_reqs();
    tick();
    push(1, 777);
    drive_reqs();
    tick();
    pend[1].delete();
    drive_reqs();
    wait_drain(200);

    // Reset in the middle of a conversion.
    begin
      int n;
      push(2, 31415);
      drive_reqs();
      n = 0;
      while (!busy && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) fail("mid_grant_timeout");
      repeat (10) tick();
      check("mid_busy_before", 64'(busy), 64'd1);
      reset_pulse();
      check("mid_busy", 64'(busy), 64'd0);
      check("mid_char_valid", 64'(char_valid), 64'd0);
      check("mid_char_data", 64'(char_data), 64'd0);
      gsrc_q.delete();
      push(2, 99999);
      push(3, 5);
      drive_reqs();
      wait_drain(300);
      check("mid_first_src", 64'(gsrc_q.size() > 0 ? gsrc_q[0] : -1), 64'd2);
      check("mid_second_src", 64'(gsrc_q.size() > 1 ? gsrc_q[1] : -1), 64'd3);
    end

    // Random traffic against the model.
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      int v, s;
      s = int'($urandom_range(0, N - 1));
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 4194303));
        1: v = int'($urandom_range(0, 99));
        2: begin
          v = p10[$urandom_range(0, 6)] - int'($urandom_range(0, 1));
        end
        default: v = 4194303;
      endcase
      push(s, v);
      drive_reqs();
      repeat ($urandom_range(0, 40)) tick();
    end
    wait_drain(20000);
    rdy_mode = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bcd_ascii_scheduler.md
Name: bcd_ascii_scheduler

Overview:
Shares one iterative binary-to-BCD converter among NREQ result producers, for example CORDIC sine, cosine and angle outputs. A round-robin arbiter grants one requester at a time. The granted 22-bit unsigned value is converted with one double-dabble step per clock. The result is streamed as 7 ASCII decimal characters, most significant digit first, over a valid/ready byte interface that feeds the LCD/UART display writer.

Parameters:
NREQ, 4, number of requesters; legal range 1..8.
BLANK, 1, 1 = leading zeros are emitted as space (0x20); 0 = zeros are emitted as 0x30.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset, synchronous, active-high
req_valid  in  NREQ  requester i has a value pending
req_data  in  NREQ*22  packed values; requester i occupies [i*22 +: 22]
req_ready  out  NREQ  one-hot grant; a transfer occurs on the edge where req_valid[i] and req_ready[i] are both 1
char_valid  out  1  char_data is valid
char_ready  in  1  sink accepts the character on this edge
char_data  out  8  ASCII character
char_src  out  3  index of the requester that owns the frame, zero-extended
char_last  out  1  high on the 7th (final) character of the frame
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE, rr pointer 0, req_ready 0, char_valid 0, char_data 0x00, char_src 0, char_last 0, busy 0.
- State machine has three states: IDLE, CONV, EMIT.
- IDLE:
  - req_ready is combinational and is nonzero only in IDLE.
  - The grant goes to the first i with req_valid[i]=1, searching from the rr pointer upward with wrap-around.
  - On the grant edge: bin <= req_data slice, bcd <= 0, iter <= 0, src <= i, pointer <= (i+1) mod NREQ, state <= CONV.
  - If no req_valid bit is set, the block stays in IDLE and the pointer is unchanged.
- CONV: each cycle performs exactly one double-dabble step.
  - Step 1: every 4-bit BCD digit >= 5 gets +3.
  - Step 2: {bcd,bin} shifts left by 1.
  - After the 22nd step, state <= EMIT and digit index <= 6.
  - The 28-bit bcd register holds 7 digits; the maximum input 4194303 fits, so no overflow is possible.
- EMIT:
  - char_valid=1, char_src=src.
  - char_data = digit + 0x30, or 0x20 when all of the following hold: BLANK=1, the digit is zero, all higher digits are zero, and index != 0. Digit 0 (units) is never blanked.
  - char_last=1 when index = 0.
  - On char_valid && char_ready the index decrements. After the index-0 character is accepted, char_valid <= 0 and state <= IDLE.
  - While char_ready is low, char_data, char_src and char_last stay stable. No character is ever dropped or duplicated.
- Timing:
  - Latency: char_valid rises exactly 22 clocks after the grant edge.
  - A frame takes at least 7 cycles.
  - With char_ready held high and requests pending, throughput is 1 frame per 30 clocks (1 IDLE + 22 CONV + 7 EMIT).
- Requester changes:
  - req_data or req_valid changing after the grant has no effect on the current frame.
  - A requester dropping req_valid before being granted is simply skipped.
- Reset asserted in any state, including mid-CONV or mid-EMIT:
  - The next edge returns the block to the reset values and the pointer to 0.
  - The partial frame is discarded and no further characters of it appear.
  - Reset has priority over a simultaneous grant or char accept.

Test Plan:
- Zero value: req_valid[0]=1, req_data[0]=0, BLANK=1 -> six 0x20 then 0x30; char_last only on the 7th character; char_src=0. With BLANK=0 -> seven 0x30.
- Full-scale value: req1 = 4194303 -> 0x34 0x31 0x39 0x34 0x33 0x30 0x33 ("4194303"). char_valid first high exactly 22 clocks after the req_ready[1] edge.
- Fairness: req_valid=4'b1111 held, values 1,2,3,4 -> frames in src order 0,1,2,3,0. Each req_ready is a single-cycle one-hot pulse. Frames start 30 clocks apart with char_ready tied high.
- Backpressure: req0 = 123456, char_ready low for 5 cycles at character 3, then random toggling -> sink receives exactly " 123456" (0x20 0x31 0x32 0x33 0x34 0x35 0x36). char_data stays stable while stalled.
- Reset mid-operation: reset at CONV cycle 10 -> next cycle busy=0, char_valid=0. A subsequent request from req2 = 99999 yields "  99999", and the arbiter search starts from index 0.
- Boundary values: 1000000 -> "1000000"; 9 -> "      9"; 10 -> "     10". Checks correct carry through the add-3 correction on every digit.
